// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } sub_state_e;

endpackage

// File: rtl/full_subtractor_gate.sv
// Gate-level full-subtractor cell: diff = A ^ B ^ bin, bout = (~A & B) | (~(A ^ B) & bin).
module full_subtractor_gate (
  input  logic A,
  input  logic B,
  input  logic bin,
  output wire  diff,
  output wire  bout
);

  wire a_x_b;
  wire a_n;
  wire axb_n;
  wire brw_gen;
  wire brw_prop;

  xor u_x0 (a_x_b, A, B);
  xor u_x1 (diff, a_x_b, bin);
  not u_n0 (a_n, A);
  not u_n1 (axb_n, a_x_b);
  and u_a0 (brw_gen, a_n, B);
  and u_a1 (brw_prop, axb_n, bin);
  or  u_o0 (bout, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  sub_state_e       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             bin;
  logic [CntW-1:0]  cnt;
  logic             d;
  logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor_gate u_fs (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .bin  (bin),
    .diff (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StIdle;
      a_sh   <= '0;
      b_sh   <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
            state  <= StShift;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            ovf    <= 1'b0;
`endif
          end
        end
        StShift: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bout;
          // diff doubles as the result shift register; it is complete after the last bit.
          diff <= {d, diff[WIDTH-1:1]};
          if (cnt == CntW'(WIDTH - 1)) begin
            cnt    <= '0;
            borrow <= bout;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= StDone;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // The final d is the result MSB.
            ovf    <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks need SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .ovf    (ovf),
`endif
    .borrow (borrow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge where done should be high.
  // If inj_cyc >= 0 a start with junk operands is pulsed during that SHIFT cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_b, input int inj_cyc);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = 8'hxx;
    B     = 8'hxx;
    for (int i = 0; i < int'(W); i++) begin
      chk("busy_in_shift", 32'(busy), 32'd1);
      chk("done_in_shift", 32'(done), 32'd0);
      if (i == inj_cyc) begin
        start = 1'b1;
        A     = 8'h11;
        B     = 8'h01;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("diff", 32'(diff), 32'(exp_d));
    chk("borrow", 32'(borrow), 32'(exp_b));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    // rst and start together: rst wins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_beats_start", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic subtraction
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, -1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Wrap-around with borrow, then hold for 5 idle cycles
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_diff", 32'(diff), 32'hFF);
      chk("hold_borrow", 32'(borrow), 32'd1);
      chk("hold_done", 32'(done), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
    end

    // Equal operands; start during DONE is ignored; back-to-back start in IDLE after done
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, -1);
    start = 1'b1;
    A     = 8'h77;
    B     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, -1);
    @(negedge clk);

    // start pulsed at SHIFT cycle 3 must be ignored
    run_op(8'h33, 8'h44, 8'hEF, 1'b1, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_second_done", 32'(done), 32'd0);
      chk("no_restart", 32'(busy), 32'd0);
    end

    // Reset at SHIFT cycle 4 aborts immediately
    start = 1'b1;
    A     = 8'hC8;
    B     = 8'h15;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Another pattern after abort recovery
    run_op(8'hC8, 8'h15, 8'hB3, 1'b0, -1);
    @(negedge clk);

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, -1);
    chk("ovf_set", 32'(ovf), 32'd1);
    @(negedge clk);
    chk("ovf_held", 32'(ovf), 32'd1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, -1);
    chk("ovf_clear", 32'(ovf), 32'd0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing A − B one bit per clock, LSB first, with a start/busy/done handshake. It is the subtracting counterpart of the team's gate-level adder cells. Each bit is produced by a gate-level full-subtractor cell, and a borrow flip-flop carries between bits. It serves datapaths that trade latency for area and need a difference and borrow rather than a sum and carry.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range WIDTH ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepted start.
- B  input  WIDTH  subtrahend; captured on the accepted start.
- busy  output  1  high while bits are being computed.
- done  output  1  one-cycle pulse when diff/borrow become valid.
- diff  output  WIDTH  A − B mod 2^WIDTH; held until the next accepted start.
- borrow  output  1  high when A < B (unsigned); held with diff.

## Operation
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start=1.
  - SHIFT → DONE when bit counter = WIDTH−1.
  - DONE → IDLE unconditionally after one cycle.
- Accepted start (IDLE only):
  - Latch A and B into shift registers a_sh and b_sh.
  - Clear the borrow flip-flop and the counter.
  - Clear diff and borrow outputs.
- SHIFT, each cycle:
  - d = a_sh[0] ^ b_sh[0] ^ bin.
  - bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin).
  - d shifts into the MSB of the result register, which shifts right.
  - a_sh and b_sh shift right; bin ← bout; counter increments.
- After WIDTH SHIFT cycles the result register holds the full diff, LSB aligned. The borrow output takes the final bout.
- start in SHIFT or DONE is ignored and not queued.
- busy = 1 exactly in SHIFT. done = 1 exactly in DONE.
- Counter width is $clog2(WIDTH). The counter wraps to 0 on the SHIFT → DONE transition.
- Reset values: busy=0, done=0, diff=0, borrow=0, state=IDLE, internal registers 0.
- Reset mid-operation aborts immediately. The next cycle is IDLE with all outputs 0, and no done is issued.
- rst and start in the same cycle: rst wins and start is dropped.

## Timing
- Start accepted at edge 0. busy is high for edges 1..WIDTH. done and valid diff/borrow appear after edge WIDTH+1.
- Latency start→done: WIDTH+1 cycles. Throughput: one operation per WIDTH+2 cycles. A back-to-back start is accepted in the IDLE cycle after done.
- diff and borrow are registered outputs with no combinational path from the inputs.
- A and B are don't-care except on the accepted-start cycle.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - Adds output port ovf (1 bit, reset 0). ovf is the two's-complement signed overflow: (A[MSB] ≠ B[MSB]) & (diff[MSB] ≠ A[MSB]).
  - ovf is registered, valid with done, and held with diff.
  - Captured sign bits add two flip-flops.
- SERIAL_SUB_OVERFLOW_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package/header serial_sub_pkg:
  - State encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- Sub-module full_subtractor_gate: gate-level primitive cell (xor/and/or/not instances) with ports A, B, bin, diff, bout. It is instantiated once for the per-bit difference and borrow.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, start one cycle → busy for 8 cycles, done after edge 9, diff=0x1E, borrow=0.
- A=0x00, B=0x01 → diff=0xFF, borrow=1; outputs held stable for 5 idle cycles after done.
- A=0xFF, B=0xFF, then a start issued in the cycle after done → first diff=0x00, borrow=0. Second operation (A=0x10, B=0x20) → diff=0xF0, borrow=1.
- start pulsed at SHIFT cycle 3 with different operands → ignored; result matches the first operands; exactly one done pulse.
- rst asserted at SHIFT cycle 4 → next cycle: state IDLE, busy=0, done=0, diff=0x00, borrow=0; no done follows.
- SERIAL_SUB_OVERFLOW_EN defined, A=0x80, B=0x01 → diff=0x7F, borrow=0, ovf=1. Then A=0x05, B=0x03 → diff=0x02, ovf=0.
